// File: rtl/game_pkg.sv
// game_pkg: phase encoding, default parameters and helpers shared by the game-flow blocks
package game_pkg;
  typedef enum logic [2:0] {
    TITLE = 3'd0,
    LOAD  = 3'd1,
    PLAY  = 3'd2,
    PAUSE = 3'd3,
    DYING = 3'd4,
    CLEAR = 3'd5,
    OVER  = 3'd6
  } phase_t;
  localparam int LIVES_INIT_D   = 3;
  localparam int GOLD_TOTAL_D   = 8;
  localparam int DEATH_FRAMES_D = 90;
  localparam int CLEAR_FRAMES_D = 120;
  function automatic logic [3:0] level_inc(input logic [3:0] l);
    return (l == 4'd15) ? l : l + 4'd1;
  endfunction
endpackage

// File: rtl/btn_rise_detect.sv
// btn_rise_detect: rising-edge detector whose history starts high so a button held through reset gives no edge
module btn_rise_detect (
  input  logic clk,
  input  logic resetN,
  input  logic btn,
  output logic rise
);
  logic prev;
  // remember last sampled button level
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) prev <= 1'b1;
    else prev <= btn;
  assign rise = btn & ~prev;
endmodule

// File: rtl/game_phase_sequencer.sv
// game_phase_sequencer: game-flow FSM driving object reset/freeze and tracking lives, level and gold
module game_phase_sequencer
  import game_pkg::*;
#(
  parameter int LIVES_INIT   = LIVES_INIT_D,
  parameter int GOLD_TOTAL   = GOLD_TOTAL_D,
  parameter int DEATH_FRAMES = DEATH_FRAMES_D,
  parameter int CLEAR_FRAMES = CLEAR_FRAMES_D
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       start_btn,
  input  logic       select_btn,
  input  logic       player_died,
  input  logic       gold_eaten,
  output logic [2:0] phase,
  output logic       objects_resetN,
  output logic       freeze,
  output logic [2:0] lives,
  output logic [3:0] level,
  output logic [7:0] gold_left,
  output logic       no_lives
);
  phase_t state_q, state_d;
  logic [2:0] lives_d;
  logic [3:0] level_d;
  logic [7:0] gold_d, cnt_q, cnt_d;
  logic start_rise, select_rise, freeze_d, ores_d, no_lives_d;
  btn_rise_detect u_start (.clk(clk), .resetN(resetN), .btn(start_btn), .rise(start_rise));
  btn_rise_detect u_select (.clk(clk), .resetN(resetN), .btn(select_btn), .rise(select_rise));
  // state, counters and registered outputs
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      state_q        <= TITLE;
      lives          <= 3'(LIVES_INIT);
      level          <= 4'd0;
      gold_left      <= 8'(GOLD_TOTAL);
      cnt_q          <= 8'd0;
      freeze         <= 1'b1;
      objects_resetN <= 1'b0;
      no_lives       <= 1'b0;
    end else begin
      state_q        <= state_d;
      lives          <= lives_d;
      level          <= level_d;
      gold_left      <= gold_d;
      cnt_q          <= cnt_d;
      freeze         <= freeze_d;
      objects_resetN <= ores_d;
      no_lives       <= no_lives_d;
    end
  // next phase and counter updates; death beats gold beats select
  always_comb begin
    state_d = state_q;
    lives_d = lives;
    level_d = level;
    gold_d  = gold_left;
    cnt_d   = (startOfFrame && (state_q == DYING || state_q == CLEAR || state_q == LOAD)) ? cnt_q + 8'd1 : cnt_q;
    case (state_q)
      TITLE:
        if (start_rise) begin
          lives_d = 3'(LIVES_INIT);
          level_d = 4'd0;
          state_d = LOAD;
        end
      LOAD:
        if (startOfFrame) state_d = PLAY;
      PLAY:
        if (player_died) begin
          lives_d = (lives <= 3'd1) ? 3'd0 : lives - 3'd1;
          state_d = (lives <= 3'd1) ? OVER : DYING;
          cnt_d   = 8'd0;
        end else if (gold_eaten) begin
          gold_d  = (gold_left != 8'd0) ? gold_left - 8'd1 : gold_left;
          state_d = (gold_left == 8'd1) ? CLEAR : PLAY;
          cnt_d   = 8'd0;
        end else if (select_rise) state_d = PAUSE;
      PAUSE:
        if (select_rise) state_d = PLAY;
      DYING:
        if (startOfFrame && cnt_q == 8'(DEATH_FRAMES - 1)) state_d = LOAD;
      CLEAR:
        if (startOfFrame && cnt_q == 8'(CLEAR_FRAMES - 1)) begin
          state_d = LOAD;
          level_d = level_inc(level);
        end
      OVER:
        if (start_rise) state_d = TITLE;
      default: state_d = TITLE;
    endcase
    if (state_d == LOAD) gold_d = 8'(GOLD_TOTAL);
  end
  // object control lines decoded from the upcoming phase so they register alongside it
  always_comb begin
    freeze_d   = state_d != PLAY;
    ores_d     = !(state_d == TITLE || state_d == LOAD);
    no_lives_d = state_d == OVER;
  end
  assign phase = state_q;
endmodule

// File: tb/tb_game_phase_sequencer.sv
// tb_game_phase_sequencer: scoreboard-driven check of the game-flow phases and counters
module tb_game_phase_sequencer;
  import game_pkg::*;
  typedef struct packed {
    logic [2:0] ph;
    logic       ores;
    logic       frz;
    logic [2:0] lives;
    logic [3:0] lvl;
    logic [7:0] gold;
    logic       nl;
  } exp_t;
  logic clk = 1'b0, resetN, sof, start_btn, select_btn, died, gold;
  logic [2:0] phase, lives;
  logic [3:0] level;
  logic [7:0] gold_left;
  logic objects_resetN, freeze, no_lives;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0;
  string ctx = "init";
  game_phase_sequencer #(
    .LIVES_INIT(3), .GOLD_TOTAL(8), .DEATH_FRAMES(90), .CLEAR_FRAMES(120)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .start_btn(start_btn),
    .select_btn(select_btn), .player_died(died), .gold_eaten(gold),
    .phase(phase), .objects_resetN(objects_resetN), .freeze(freeze),
    .lives(lives), .level(level), .gold_left(gold_left), .no_lives(no_lives)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0d expected %0d", ctx, tag, got, exp);
    end
  endtask
  function automatic exp_t mk(input phase_t p, input int lv, input int lvl, input int gl);
    exp_t e;
    e.ph    = p;
    e.lives = 3'(lv);
    e.lvl   = 4'(lvl);
    e.gold  = 8'(gl);
    e.frz   = p != PLAY;
    e.ores  = !(p == TITLE || p == LOAD);
    e.nl    = p == OVER;
    return e;
  endfunction
  task automatic pop_compare();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    check("phase", phase, e.ph);
    check("objects_resetN", objects_resetN, e.ores);
    check("freeze", freeze, e.frz);
    check("lives", lives, e.lives);
    check("level", level, e.lvl);
    check("gold_left", gold_left, e.gold);
    check("no_lives", no_lives, e.nl);
  endtask
  task automatic step(input bit s, input bit d, input bit g, input exp_t e);
    sof = s; died = d; gold = g;
    sb.push_back(e);
    @(negedge clk);
    sof = 0; died = 0; gold = 0;
    pop_compare();
  endtask
  task automatic run(input bit s, input bit d, input bit g);
    sof = s; died = d; gold = g;
    @(negedge clk);
    sof = 0; died = 0; gold = 0;
  endtask
  task automatic check_now(input exp_t e);
    sb.push_back(e);
    pop_compare();
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
  initial begin
    resetN = 0; start_btn = 1; select_btn = 0; sof = 0; died = 0; gold = 0;
    @(negedge clk);
    ctx = "reset";
    step(0, 0, 0, mk(TITLE, 3, 0, 8));
    resetN = 1;
    ctx = "held_start";
    repeat (2) step(0, 0, 0, mk(TITLE, 3, 0, 8));
    start_btn = 0;
    step(0, 0, 0, mk(TITLE, 3, 0, 8));
    ctx = "start";
    start_btn = 1;
    step(0, 0, 0, mk(LOAD, 3, 0, 8));
    start_btn = 0;
    ctx = "load_wait";
    step(0, 0, 0, mk(LOAD, 3, 0, 8));
    ctx = "load_exit";
    step(1, 0, 0, mk(PLAY, 3, 0, 8));
    ctx = "gold";
    for (int i = 7; i >= 1; i--) step(0, 0, 1, mk(PLAY, 3, 0, i));
    step(0, 0, 1, mk(CLEAR, 3, 0, 0));
    ctx = "clear_frames";
    for (int i = 0; i < 119; i++) begin
      step(1, 0, 0, mk(CLEAR, 3, 0, 0));
      run(0, 0, 0);
    end
    step(1, 0, 0, mk(LOAD, 3, 1, 8));
    step(0, 0, 0, mk(LOAD, 3, 1, 8));
    step(1, 0, 0, mk(PLAY, 3, 1, 8));
    ctx = "death1";
    step(0, 1, 0, mk(DYING, 2, 1, 8));
    for (int i = 0; i < 89; i++) step(1, 0, 0, mk(DYING, 2, 1, 8));
    step(1, 0, 0, mk(LOAD, 2, 1, 8));
    step(1, 0, 0, mk(PLAY, 2, 1, 8));
    ctx = "gold_to_1";
    for (int i = 7; i >= 1; i--) step(0, 0, 1, mk(PLAY, 2, 1, i));
    ctx = "death_and_gold";
    step(0, 1, 1, mk(DYING, 1, 1, 1));
    repeat (89) run(1, 0, 0);
    step(1, 0, 0, mk(LOAD, 1, 1, 8));
    step(1, 0, 0, mk(PLAY, 1, 1, 8));
    ctx = "last_death";
    step(0, 1, 0, mk(OVER, 0, 1, 8));
    ctx = "over_ignore";
    step(0, 1, 1, mk(OVER, 0, 1, 8));
    ctx = "over_start";
    start_btn = 1;
    step(0, 0, 0, mk(TITLE, 0, 1, 8));
    start_btn = 0;
    step(0, 0, 0, mk(TITLE, 0, 1, 8));
    start_btn = 1;
    step(0, 0, 0, mk(LOAD, 3, 0, 8));
    start_btn = 0;
    step(1, 0, 0, mk(PLAY, 3, 0, 8));
    ctx = "pause";
    select_btn = 1;
    step(0, 0, 0, mk(PAUSE, 3, 0, 8));
    step(0, 1, 0, mk(PAUSE, 3, 0, 8));
    step(0, 0, 1, mk(PAUSE, 3, 0, 8));
    step(1, 0, 0, mk(PAUSE, 3, 0, 8));
    start_btn = 1;
    step(0, 0, 0, mk(PAUSE, 3, 0, 8));
    start_btn = 0;
    select_btn = 0;
    step(0, 0, 0, mk(PAUSE, 3, 0, 8));
    ctx = "resume";
    select_btn = 1;
    step(0, 0, 0, mk(PLAY, 3, 0, 8));
    step(0, 0, 0, mk(PLAY, 3, 0, 8));
    select_btn = 0;
    step(0, 0, 0, mk(PLAY, 3, 0, 8));
    ctx = "climb";
    for (int l = 0; l < 5; l++) begin
      repeat (8) run(0, 0, 1);
      repeat (120) run(1, 0, 0);
      run(1, 0, 0);
    end
    step(0, 0, 0, mk(PLAY, 3, 5, 8));
    repeat (7) run(0, 0, 1);
    step(0, 0, 1, mk(CLEAR, 3, 5, 0));
    repeat (10) run(1, 0, 0);
    ctx = "async_reset";
    #2 resetN = 0;
    #1 check_now(mk(TITLE, 3, 0, 8));
    @(negedge clk);
    step(1, 0, 0, mk(TITLE, 3, 0, 8));
    resetN = 1;
    ctx = "after_reset";
    step(0, 0, 0, mk(TITLE, 3, 0, 8));
    start_btn = 1;
    step(0, 0, 0, mk(LOAD, 3, 0, 8));
    start_btn = 0;
    step(1, 0, 0, mk(PLAY, 3, 0, 8));
    ctx = "fresh_clear";
    repeat (7) run(0, 0, 1);
    step(0, 0, 1, mk(CLEAR, 3, 0, 0));
    repeat (119) run(1, 0, 0);
    step(0, 0, 0, mk(CLEAR, 3, 0, 0));
    step(1, 0, 0, mk(LOAD, 3, 1, 8));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
